data_mem_lsu: RTL and testbench

//  Parametrised successor to the single-port word data memory. Adds byte/half/word loads and stores,
//  per-byte write strobes, sign/zero extension, misalignment and range faults, a registered read with
//  a req/rsp valid handshake, and a saturating fault counter. Sits between the execute stage and the

---
 rtl/data_mem_pkg.sv | 24 ++
 rtl/data_mem_lane_align.sv | 54 +++++
 rtl/data_mem_lsu.sv | 100 ++++++++++
 tb/tb_data_mem_lsu.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared encodings and helpers for the data-memory load/store unit.
package data_mem_pkg;

  localparam int unsigned LANE_W = 8;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned DATA_W = STRB_W * LANE_W;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_ILL = 2'b11
  } size_e;

  // Halves need even addresses, words need 4-byte alignment; bytes never misalign.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
    case (size)
      SZ_H:    return addr_lo[0];
      SZ_W:    return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_lane_align.sv
// Byte-lane steering: store replication/strobes and load extraction/extension.
module data_mem_lane_align
  import data_mem_pkg::*;
(
  input  size_e             size_i,
  input  logic [1:0]        lane_i,
  input  logic              unsigned_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rword_i,
  output logic [DATA_W-1:0] wdata_lanes_c_o,
  output logic [STRB_W-1:0] strb_c_o,
  output logic [DATA_W-1:0] load_data_c_o
);

  logic [LANE_W-1:0]   byte_sel;
  logic [2*LANE_W-1:0] half_sel;

  // Store path: replicate the right-aligned datum across lanes, strobe only the target ones.
  always_comb begin
    wdata_lanes_c_o = '0;
    strb_c_o        = '0;
    case (size_i)
      SZ_B: begin
        wdata_lanes_c_o = {STRB_W{wdata_i[LANE_W-1:0]}};
        strb_c_o        = STRB_W'(1) << lane_i;
      end
      SZ_H: begin
        wdata_lanes_c_o = {(STRB_W/2){wdata_i[2*LANE_W-1:0]}};
        strb_c_o        = lane_i[1] ? 4'b1100 : 4'b0011;
      end
      SZ_W: begin
        wdata_lanes_c_o = wdata_i;
        strb_c_o        = '1;
      end
      default: ;
    endcase
  end

  // Load path: pick the addressed lane(s) and extend to full width.
  always_comb begin
    byte_sel      = rword_i[{lane_i, 3'b000} +: LANE_W];
    half_sel      = rword_i[{lane_i[1], 4'b0000} +: 2*LANE_W];
    load_data_c_o = '0;
    case (size_i)
      SZ_B: load_data_c_o = unsigned_i ? DATA_W'(byte_sel)
                                       : {{(DATA_W-LANE_W){byte_sel[LANE_W-1]}}, byte_sel};
      SZ_H: load_data_c_o = unsigned_i ? DATA_W'(half_sel)
                                       : {{(DATA_W-2*LANE_W){half_sel[2*LANE_W-1]}}, half_sel};
      SZ_W: load_data_c_o = rword_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Data memory with byte/half/word access, fault detection, registered response and fault counter.
module data_mem_lsu
  import data_mem_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned ERRCNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                rsp_valid,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic                rsp_err,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic [XLEN-1:0]     mem [DEPTH_WORDS];

  size_e               size;
  logic [1:0]          lane;
  logic [IDX_W-1:0]    word_idx;
  logic                out_of_range;
  logic                fault;
  logic                store_en;
  logic [XLEN-1:0]     rword;
  logic [XLEN-1:0]     wdata_lanes;
  logic [STRB_W-1:0]   strb;
  logic [XLEN-1:0]     load_data;

  logic                rsp_valid_d, rsp_valid_q;
  logic                rsp_err_d,   rsp_err_q;
  logic [XLEN-1:0]     rsp_rdata_d, rsp_rdata_q;
  logic [ERRCNT_W-1:0] err_cnt_d,   err_cnt_q;

  assign size         = size_e'(req_size);
  assign lane         = req_addr[1:0];
  assign word_idx     = req_addr[IDX_W+1:2];
  assign out_of_range = |req_addr[ADDR_W-1:IDX_W+2];
  assign fault        = (size == SZ_ILL) | is_misaligned(size, lane) | out_of_range;
  assign store_en     = req_valid & req_we & ~fault;
  assign rword        = mem[word_idx];

  data_mem_lane_align u_align (
    .size_i          (size),
    .lane_i          (lane),
    .unsigned_i      (req_unsigned),
    .wdata_i         (req_wdata),
    .rword_i         (rword),
    .wdata_lanes_c_o (wdata_lanes),
    .strb_c_o        (strb),
    .load_data_c_o   (load_data)
  );

  // Array is deliberately unreset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (strb[b]) mem[word_idx][b*LANE_W +: LANE_W] <= wdata_lanes[b*LANE_W +: LANE_W];
      end
    end
  end

  always_comb begin
    rsp_valid_d = req_valid;
    rsp_err_d   = req_valid & fault;
    rsp_rdata_d = '0;
    err_cnt_d   = err_cnt_q;
    if (req_valid && !req_we && !fault) rsp_rdata_d = load_data;
    if (req_valid && fault && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERRCNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed self-checking bench for data_mem_lsu.
module tb_data_mem_lsu;
  import data_mem_pkg::*;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned ECW   = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid;
  logic            req_we;
  logic [31:0]     req_addr;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [31:0]     req_wdata;
  logic            rsp_valid;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;
  logic [ECW-1:0]  err_count;

  int checks = 0;
  int errors = 0;

  data_mem_lsu #(
    .XLEN(32), .DEPTH_WORDS(DEPTH), .ADDR_W(32), .ERRCNT_W(ECW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Drive a request (called at a negedge) and advance to the next negedge where its response is visible.
  task automatic req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                     input logic uns, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wd;
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, err_count} !== {1'b1 & 1'b0, 1'b0, 32'h0, 3'd0}) begin
      errors++;
      $display("FAIL reset: valid=%b err=%b rdata=%h cnt=%0d expected all zero",
               rsp_valid, rsp_err, rsp_rdata, err_count);
    end
  endtask

  task automatic test_word();
    logic [31:0] exp [2];
    exp[0] = 32'hAAAABBBB; exp[1] = 32'h12345678;
    for (int i = 0; i < 2; i++) begin
      req(1'b1, 32'(4*i), SZ_W, 1'b0, exp[i]);
      checks++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
        errors++;
        $display("FAIL sw_rsp[%0d]: v=%b e=%b d=%h expected 1 0 00000000", i, rsp_valid, rsp_err, rsp_rdata);
      end
    end
    for (int i = 0; i < 2; i++) begin
      req(1'b0, 32'(4*i), SZ_W, 1'b0, 32'h0);
      checks++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, exp[i]}) begin
        errors++;
        $display("FAIL lw[%0d]: v=%b e=%b d=%h expected 1 0 %h", i, rsp_valid, rsp_err, rsp_rdata, exp[i]);
      end
    end
    idle();
  endtask

  task automatic test_byte();
    logic [31:0] a  [5];
    logic [1:0]  sz [5];
    logic        u  [5];
    logic [31:0] e  [5];
    a[0]=32'h8; sz[0]=SZ_B; u[0]=0; e[0]=32'h00000044;
    a[1]=32'hB; sz[1]=SZ_B; u[1]=0; e[1]=32'h00000011;
    a[2]=32'h9; sz[2]=SZ_B; u[2]=0; e[2]=32'hFFFFFF80;
    a[3]=32'h9; sz[3]=SZ_B; u[3]=1; e[3]=32'h00000080;
    a[4]=32'h8; sz[4]=SZ_W; u[4]=0; e[4]=32'h11228044;
    req(1'b1, 32'h8, SZ_W, 1'b0, 32'h11223344);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) req(1'b1, 32'h9, SZ_B, 1'b0, 32'hFFFFFF80);
      req(1'b0, a[i], sz[i], u[i], 32'h0);
      checks++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, e[i]}) begin
        errors++;
        $display("FAIL byte_ld[%0d]: v=%b e=%b d=%h expected 1 0 %h", i, rsp_valid, rsp_err, rsp_rdata, e[i]);
      end
    end
    idle();
  endtask

  task automatic test_half();
    logic [31:0] a  [3];
    logic [1:0]  sz [3];
    logic        u  [3];
    logic [31:0] e  [3];
    a[0]=32'hE; sz[0]=SZ_H; u[0]=0; e[0]=32'hFFFFBEEF;
    a[1]=32'hE; sz[1]=SZ_H; u[1]=1; e[1]=32'h0000BEEF;
    a[2]=32'hC; sz[2]=SZ_W; u[2]=0; e[2]=32'hBEEF0000;
    req(1'b1, 32'hC, SZ_W, 1'b0, 32'h00000000);
    req(1'b1, 32'hE, SZ_H, 1'b0, 32'h1234BEEF);
    for (int i = 0; i < 3; i++) begin
      req(1'b0, a[i], sz[i], u[i], 32'h0);
      checks++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, e[i]}) begin
        errors++;
        $display("FAIL half_ld[%0d]: v=%b e=%b d=%h expected 1 0 %h", i, rsp_valid, rsp_err, rsp_rdata, e[i]);
      end
    end
    idle();
  endtask

  task automatic test_faults();
    logic        we [4];
    logic [31:0] a  [4];
    logic [1:0]  sz [4];
    we[0]=0; a[0]=32'h2;        sz[0]=SZ_W;
    we[1]=0; a[1]=32'h1;        sz[1]=SZ_H;
    we[2]=0; a[2]=32'h0;        sz[2]=2'b11;
    we[3]=1; a[3]=32'(DEPTH*4); sz[3]=SZ_W;
    for (int i = 0; i < 4; i++) begin
      req(we[i], a[i], sz[i], 1'b0, 32'hDEADBEEF);
      checks++;
      if ({rsp_valid, rsp_err, rsp_rdata, err_count} !== {1'b1, 1'b1, 32'h0, 3'(i+1)}) begin
        errors++;
        $display("FAIL fault[%0d]: v=%b e=%b d=%h cnt=%0d expected 1 1 00000000 %0d",
                 i, rsp_valid, rsp_err, rsp_rdata, err_count, i+1);
      end
    end
    req(1'b0, 32'h0, SZ_W, 1'b0, 32'h0);
    checks++;
    if ({rsp_err, rsp_rdata, err_count} !== {1'b0, 32'hAAAABBBB, 3'd4}) begin
      errors++;
      $display("FAIL fault_nochange: e=%b d=%h cnt=%0d expected 0 aaaabbbb 4", rsp_err, rsp_rdata, err_count);
    end
    req(1'b1, 32'(DEPTH*4-4), SZ_W, 1'b0, 32'hCAFEF00D);
    req(1'b0, 32'(DEPTH*4-4), SZ_W, 1'b0, 32'h0);
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL top_word: v=%b e=%b d=%h expected 1 0 cafef00d", rsp_valid, rsp_err, rsp_rdata);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    req(1'b1, 32'h10, SZ_W, 1'b0, 32'h55667788);
    req(1'b0, 32'h10, SZ_W, 1'b0, 32'h0);
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h55667788}) begin
      errors++;
      $display("FAIL b2b_ld: v=%b e=%b d=%h expected 1 0 55667788", rsp_valid, rsp_err, rsp_rdata);
    end
    for (int i = 0; i < 2; i++) begin
      idle();
      checks++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b0, 1'b0, 32'h0}) begin
        errors++;
        $display("FAIL idle[%0d]: v=%b e=%b d=%h expected 0 0 00000000", i, rsp_valid, rsp_err, rsp_rdata);
      end
    end
  endtask

  task automatic test_reset_mid();
    req(1'b0, 32'h4, SZ_W, 1'b0, 32'h0);
    req_valid = 1'b1; req_addr = 32'h0;
    #2;
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, err_count} !== {1'b0, 1'b0, 32'h0, 3'd0}) begin
      errors++;
      $display("FAIL rst_async: v=%b e=%b d=%h cnt=%0d expected all zero", rsp_valid, rsp_err, rsp_rdata, err_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_drop: v=%b expected 0", rsp_valid);
    end
    req(1'b0, 32'h4, SZ_W, 1'b0, 32'h0);
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, err_count} !== {1'b1, 1'b0, 32'h12345678, 3'd0}) begin
      errors++;
      $display("FAIL rst_keep: v=%b e=%b d=%h cnt=%0d expected 1 0 12345678 0",
               rsp_valid, rsp_err, rsp_rdata, err_count);
    end
    idle();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 7; i++) req(1'b0, 32'h0, 2'b11, 1'b0, 32'h0);
    checks++;
    if (err_count !== 3'd7) begin
      errors++;
      $display("FAIL sat_reach: cnt=%0d expected 7", err_count);
    end
    for (int i = 0; i < 3; i++) req(1'b0, 32'h3, SZ_H, 1'b0, 32'h0);
    checks++;
    if ({rsp_err, err_count} !== {1'b1, 3'd7}) begin
      errors++;
      $display("FAIL sat_hold: e=%b cnt=%0d expected 1 7", rsp_err, err_count);
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_word();
    test_byte();
    test_half();
    test_faults();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
